// File: rtl/disp_pkg.sv
// Display code definitions shared by the digit scan controller and the
// 7-segment code decoder.
//
// Contents:
//   disp_code_t       4-bit display code (0-9 are digits, the rest are glyphs)
//   CODE_* constants  named glyph codes
//   is_zero_or_blank  helper used by leading-zero suppression
package disp_pkg;

    typedef logic [3:0] disp_code_t;

    localparam disp_code_t CODE_ZERO  = 4'b0000;
    localparam disp_code_t CODE_L     = 4'b1010;
    localparam disp_code_t CODE_C     = 4'b1011;
    localparam disp_code_t CODE_BLANK = 4'b1100;
    localparam disp_code_t CODE_P     = 4'b1101;
    localparam disp_code_t CODE_N     = 4'b1110;
    localparam disp_code_t CODE_A     = 4'b1111;

    // True when a digit contributes nothing visible to the left of a number.
    function automatic logic is_zero_or_blank(input disp_code_t code);
        return (code == CODE_ZERO) || (code == CODE_BLANK);
    endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Generic modulo-SCAN_DIV tick generator. The counter runs 0..SCAN_DIV-1
// and wraps; tick is high (combinationally) while the count sits at its
// last value, so downstream logic acts on the wrapping edge.
//
// Ports:
//   clk    in   system clock
//   reset  in   asynchronous, active-high reset (count returns to 0)
//   tick   out  high for one cycle out of every SCAN_DIV
module scan_prescaler #(
    parameter int SCAN_DIV = 50000
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] LAST_COUNT = CW'(SCAN_DIV - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Wrap to zero on the terminal count instead of relying on overflow,
    // so non-power-of-two dividers work.
    always_comb begin
        tick    = (count_q == LAST_COUNT);
        count_d = tick ? '0 : count_q + CW'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/digit_scan_ctrl.sv
// Digit scan controller: holds a frame of DIGITS 4-bit display codes and
// time-multiplexes them, one digit per scan slot, onto the decoder's num
// input together with an active-low digit select. dig_sel trails num by
// one clock so it lines up with the decoder's registered segment output.
// New frames arrive over a valid/ready handshake into a pending buffer and
// are swapped into the display buffer only on a frame boundary.
//
// Optional build macro:
//   LEADING_ZERO_BLANK_EN  blank zero digits that have only zero/blank
//                          digits above them (digit 0 is always shown)
//
// Ports:
//   clk         in   system clock
//   reset       in   asynchronous, active-high reset
//   ld_valid    in   producer offers ld_data
//   ld_ready    out  a new frame can be accepted
//   ld_data     in   frame codes, digit i in bits [4i+3:4i], digit 0 rightmost
//   blink_mask  in   bit i set: digit i blinks (sampled live)
//   num         out  code for the decoder
//   dig_sel     out  active-low one-hot digit enable
//   frame_tick  out  one-cycle pulse after every frame boundary
module digit_scan_ctrl #(
    parameter int DIGITS       = 4,
    parameter int SCAN_DIV     = 50000,
    parameter int BLINK_FRAMES = 128
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ld_valid,
    output logic                  ld_ready,
    input  logic [4*DIGITS-1:0]   ld_data,
    input  logic [DIGITS-1:0]     blink_mask,
    output logic [3:0]            num,
    output logic [DIGITS-1:0]     dig_sel,
    output logic                  frame_tick
);

    import disp_pkg::*;

    localparam int IW = $clog2(DIGITS);
    localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS - 1);

    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

    localparam logic [0:0] PHASE_OFF = 1'b0;
    localparam logic [0:0] PHASE_ON  = 1'b1;

    logic                 slot_end;
    logic                 frame_end;
    logic                 accept;
    logic                 swap;

    logic [IW-1:0]        idx_q, idx_d;
    logic [4*DIGITS-1:0]  disp_q, disp_d;
    logic [4*DIGITS-1:0]  pend_q, pend_d;
    logic                 ld_ready_q, ld_ready_d;
    logic                 frame_tick_q, frame_tick_d;
    logic [BW-1:0]        blink_cnt_q, blink_cnt_d;
    logic [0:0]           phase_q, phase_d;
    disp_code_t           num_q, num_d;
    logic [DIGITS-1:0]    dig_sel_q, dig_sel_d;

    disp_code_t           code_sel;
    logic                 mask_sel;
    logic                 lz_sel;
    logic [DIGITS-1:0]    lz_vec;

    scan_prescaler #(
        .SCAN_DIV (SCAN_DIV)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .tick  (slot_end)
    );

    // Digit index, handshake and buffer swap. ld_ready low means the pending
    // buffer holds an accepted frame, so the swap keys off that alone; a frame
    // accepted on the frame_end edge therefore waits a full frame.
    always_comb begin
        frame_end = slot_end && (idx_q == LAST_IDX);
        idx_d     = idx_q;
        if (slot_end) begin
            idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + IW'(1);
        end

        accept = ld_valid && ld_ready_q;
        swap   = frame_end && !ld_ready_q;

        pend_d     = accept ? ld_data : pend_q;
        disp_d     = swap ? pend_q : disp_q;
        ld_ready_d = ld_ready_q;
        if (accept) begin
            ld_ready_d = 1'b0;
        end
        if (swap) begin
            ld_ready_d = 1'b1;
        end

        frame_tick_d = frame_end;
    end

    // Blink phase flips every BLINK_FRAMES frames.
    always_comb begin
        blink_cnt_d = blink_cnt_q;
        phase_d     = phase_q;
        if (frame_end) begin
            if (blink_cnt_q == BLINK_LAST) begin
                blink_cnt_d = '0;
                phase_d     = ~phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + BW'(1);
            end
        end
    end

    // Selection uses next-state buffer, index and phase so the first digit
    // of a frame already reflects the swapped contents and the new phase.
    always_comb begin
        code_sel = CODE_BLANK;
        mask_sel = 1'b0;
        lz_sel   = 1'b0;
        lz_vec   = '0;
`ifdef LEADING_ZERO_BLANK_EN
        begin : lz_scan
            logic higher_clear;
            higher_clear = 1'b1;
            // Walk from the leftmost digit down; a zero is leading while
            // everything to its left is zero or blank.
            for (int i = DIGITS - 1; i >= 0; i--) begin
                lz_vec[i]    = (i != 0) && higher_clear &&
                               (disp_d[4*i +: 4] == CODE_ZERO);
                higher_clear = higher_clear && is_zero_or_blank(disp_d[4*i +: 4]);
            end
        end
`endif
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_d == IW'(i)) begin
                code_sel = disp_d[4*i +: 4];
                mask_sel = blink_mask[i];
                lz_sel   = lz_vec[i];
            end
        end

        num_d = num_q;
        if (slot_end) begin
            num_d = code_sel;
            if (lz_sel) begin
                num_d = CODE_BLANK;
            end
            if (mask_sel && (phase_d == PHASE_OFF)) begin
                num_d = CODE_BLANK;
            end
        end

        // num_q always belongs to idx_q, so this lags num by one clock.
        dig_sel_d = ~(DIGITS'(1) << idx_q);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx_q        <= '0;
            disp_q       <= {DIGITS{CODE_BLANK}};
            pend_q       <= {DIGITS{CODE_BLANK}};
            ld_ready_q   <= 1'b1;
            frame_tick_q <= 1'b0;
            blink_cnt_q  <= '0;
            phase_q      <= PHASE_ON;
            num_q        <= CODE_BLANK;
            dig_sel_q    <= '1;
        end else begin
            idx_q        <= idx_d;
            disp_q       <= disp_d;
            pend_q       <= pend_d;
            ld_ready_q   <= ld_ready_d;
            frame_tick_q <= frame_tick_d;
            blink_cnt_q  <= blink_cnt_d;
            phase_q      <= phase_d;
            num_q        <= num_d;
            dig_sel_q    <= dig_sel_d;
        end
    end

    assign ld_ready   = ld_ready_q;
    assign frame_tick = frame_tick_q;
    assign num        = num_q;
    assign dig_sel    = dig_sel_q;

endmodule

// File: tb/tb_digit_scan_ctrl.sv
// Directed testbench for digit_scan_ctrl with DIGITS=4, SCAN_DIV=4,
// BLINK_FRAMES=2. Inputs are driven and outputs sampled on the falling edge.
module tb_digit_scan_ctrl;

    logic        clk;
    logic        reset;
    logic        ld_valid;
    logic        ld_ready;
    logic [15:0] ld_data;
    logic [3:0]  blink_mask;
    logic [3:0]  num;
    logic [3:0]  dig_sel;
    logic        frame_tick;

    int checkCount = 0;
    int errorCount = 0;

    digit_scan_ctrl #(
        .DIGITS       (4),
        .SCAN_DIV     (4),
        .BLINK_FRAMES (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .ld_valid   (ld_valid),
        .ld_ready   (ld_ready),
        .ld_data    (ld_data),
        .blink_mask (blink_mask),
        .num        (num),
        .dig_sel    (dig_sel),
        .frame_tick (frame_tick)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Safety net so the run can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    // Single comparison point for every check.
    task automatic checkOutput(input string tag, input logic [15:0] observed,
                               input logic [15:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic [15:0] data);
        ld_valid = valid;
        ld_data  = data;
    endtask

    // Offer a frame for exactly one cycle.
    task automatic loadFrame(input logic [15:0] data);
        applyStimulus(1'b1, data);
        @(negedge clk);
        applyStimulus(1'b0, data);
    endtask

    // Returns on the falling edge where frame_tick is seen high.
    task automatic waitFrameTick(input string tag);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_tick && n < 40);
        if (!frame_tick) begin
            checkCount++;
            errorCount++;
            $display("[TB] FAIL %s frame_tick timeout observed=0 expected=1", tag);
        end
    endtask

    // Expected dig_sel for sample j of a frame (j=0 is the frame_tick cycle,
    // where the select still points at digit 3).
    function automatic logic [3:0] expSel(input int j);
        if (j == 0)       return 4'b0111;
        else if (j <= 4)  return 4'b1110;
        else if (j <= 8)  return 4'b1101;
        else if (j <= 12) return 4'b1011;
        else              return 4'b0111;
    endfunction

    // Checks one full frame starting at the frame_tick sample.
    task automatic checkFrame(input string tag, input logic [15:0] codes);
        for (int j = 0; j < 16; j++) begin
            if (j != 0) @(negedge clk);
            checkOutput({tag, "_num"}, {12'h0, num}, {12'h0, codes[4*(j/4) +: 4]});
            checkOutput({tag, "_sel"}, {12'h0, dig_sel}, {12'h0, expSel(j)});
        end
    endtask

    task automatic doReset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset      = 1'b1;
        blink_mask = 4'b0000;
        applyStimulus(1'b0, 16'h0000);
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Reset mid-scan with a frame pending
        @(negedge clk);
        loadFrame(16'h4321);
        repeat (5) @(negedge clk);
        checkOutput("pre_reset_ready", {15'h0, ld_ready}, 16'h0000);
        reset = 1'b1;
        #1;
        checkOutput("rst_num",   {12'h0, num},        16'h000C);
        checkOutput("rst_sel",   {12'h0, dig_sel},    16'h000F);
        checkOutput("rst_ready", {15'h0, ld_ready},   16'h0001);
        checkOutput("rst_tick",  {15'h0, frame_tick}, 16'h0000);
        @(negedge clk);
        reset = 1'b0;
        waitFrameTick("t1");
        checkOutput("t1_ready", {15'h0, ld_ready}, 16'h0001);
        checkFrame("t1_blank", 16'hCCCC);

        // Basic load, ready held low until the frame boundary
        repeat (2) @(negedge clk);
        loadFrame(16'h4321);
        checkOutput("t2_ready_drop", {15'h0, ld_ready}, 16'h0000);
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (frame_tick) break;
            checkOutput("t2_ready_low", {15'h0, ld_ready}, 16'h0000);
        end
        checkOutput("t2_tick", {15'h0, frame_tick}, 16'h0001);
        checkOutput("t2_ready_back", {15'h0, ld_ready}, 16'h0001);
        checkFrame("t2_frame", 16'h4321);

        // Second offer while busy is ignored until ready returns
        repeat (2) @(negedge clk);
        loadFrame(16'h4321);
        applyStimulus(1'b1, 16'hABCD);
        checkOutput("t3_busy", {15'h0, ld_ready}, 16'h0000);
        waitFrameTick("t3a");
        checkOutput("t3_ready", {15'h0, ld_ready}, 16'h0001);
        checkFrame("t3_old", 16'h4321);
        applyStimulus(1'b0, 16'h0000);
        waitFrameTick("t3b");
        checkFrame("t3_new", 16'hABCD);

        // Offer on the frame_end cycle waits a whole frame
        checkOutput("t4_ready_pre", {15'h0, ld_ready}, 16'h0001);
        applyStimulus(1'b1, 16'h2468);
        @(negedge clk);
        applyStimulus(1'b0, 16'h0000);
        checkOutput("t4_tick", {15'h0, frame_tick}, 16'h0001);
        checkOutput("t4_captured", {15'h0, ld_ready}, 16'h0000);
        checkFrame("t4_still_old", 16'hABCD);
        waitFrameTick("t4");
        checkOutput("t4_ready", {15'h0, ld_ready}, 16'h0001);
        checkFrame("t4_new", 16'h2468);

        // Blink on digit 1, phase known from reset
        blink_mask = 4'b0010;
        doReset();
        loadFrame(16'h4321);
        waitFrameTick("t5_f1");
        checkFrame("t5_f1_on", 16'h4321);
        waitFrameTick("t5_f2");
        checkFrame("t5_f2_off", 16'h43C1);
        waitFrameTick("t5_f3");
        checkFrame("t5_f3_off", 16'h43C1);
        waitFrameTick("t5_f4");
        checkFrame("t5_f4_on", 16'h4321);
        waitFrameTick("t5_f5");
        checkFrame("t5_f5_on", 16'h4321);
        waitFrameTick("t5_f6");
        checkFrame("t5_f6_off", 16'h43C1);

        // Leading zeros
        blink_mask = 4'b0000;
        repeat (2) @(negedge clk);
        loadFrame(16'h0050);
        waitFrameTick("t6a");
`ifdef LEADING_ZERO_BLANK_EN
        checkFrame("t6_0050", 16'hCC50);
`else
        checkFrame("t6_0050", 16'h0050);
`endif
        repeat (2) @(negedge clk);
        loadFrame(16'h0000);
        waitFrameTick("t6b");
`ifdef LEADING_ZERO_BLANK_EN
        checkFrame("t6_0000", 16'hCCC0);
`else
        checkFrame("t6_0000", 16'h0000);
`endif

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/digit_scan_ctrl.md
Name: digit_scan_ctrl

Overview:
- Upstream feeder for the 7-segment code decoder. Holds a DIGITS-wide buffer of 4-bit display codes (0-9, L, C, blank, P, N, A) and time-multiplexes one code at a time onto num.
- Drives the matching active-low digit select. dig_sel is delayed one clock to align with the decoder's registered segment output.
- New frame contents are loaded through a valid/ready handshake. They are swapped in only at frame boundaries, so a frame never mixes old and new contents.
- Supports per-digit blinking.

Parameters:
- DIGITS, 4, number of digit positions scanned; at least 2.
- SCAN_DIV, 50000, clk cycles each digit stays active; at least 2.
- BLINK_FRAMES, 128, full scan frames per blink half-period; at least 1.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset; clock is clk.
- ld_valid  in  1  producer offers ld_data.
- ld_ready  out  1  block can accept a new frame.
- ld_data  in  4*DIGITS  frame codes; bits [4i+3:4i] belong to digit i, and digit 0 is the rightmost.
- blink_mask  in  DIGITS  bit i set: digit i blinks. Sampled live, not buffered.
- num  out  4  code for the decoder's num input.
- dig_sel  out  DIGITS  active-low one-hot digit enable.
- frame_tick  out  1  one-cycle pulse at every frame boundary.

Behaviour:
- Reset values (asynchronous):
  - num=4'b1100 (blank); dig_sel all ones.
  - Display buffer and pending buffer all 4'b1100.
  - ld_ready=1, frame_tick=0, digit index=0, prescaler=0, blink phase=ON, blink counter=0.
- Reset asserted mid-frame or mid-handshake discards the pending frame. No partial state survives.
- Prescaler:
  - Counts 0..SCAN_DIV-1 and wraps.
  - slot_end is asserted when the count equals SCAN_DIV-1.
  - Width is $clog2(SCAN_DIV).
- Digit index:
  - Advances on slot_end, running 0,1,..,DIGITS-1 and wrapping to 0.
  - frame_end = slot_end AND index==DIGITS-1.
- num:
  - Registered, and updates in the cycle after slot_end with the code of the new index.
  - If that digit's blink_mask bit is 1 and blink phase is OFF, num=4'b1100 instead.
- dig_sel:
  - Registered one cycle after num; only the bit for the index shown in the previous cycle's num is 0.
  - Net result: the decoder's registered output and dig_sel change on the same edge.
- Handshake:
  - Transfer occurs when ld_valid and ld_ready are both 1 on a rising edge; ld_data is captured into the pending buffer.
  - ld_ready drops the next cycle.
  - On the next frame_end, display buffer <= pending buffer; ld_ready returns to 1 the following cycle.
  - ld_valid with ld_ready=0 is ignored; the producer must hold ld_valid.
- Transfer in the same cycle as frame_end: capture happens, but the swap waits for the following frame_end. A frame can never be swapped in the cycle it is accepted.
- frame_tick: registered pulse in the cycle after frame_end, coincident with the buffer swap becoming visible.
- Blink: the blink counter increments on frame_end. At BLINK_FRAMES-1 it clears and the blink phase toggles.
- A frame with no pending load keeps the display buffer unchanged indefinitely.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- When defined:
  - When num is generated, code 4'b0000 is replaced by 4'b1100 if every higher-index digit in the display buffer is also 0 or blank.
  - Digit 0 is never suppressed.
  - The blink override still applies on top.
- When undefined: codes pass through unmodified, apart from blink.

Decomposition:
- Package disp_pkg:
  - Code constants: CODE_BLANK=4'b1100, CODE_L=4'b1010, CODE_C=4'b1011, CODE_P=4'b1101, CODE_N=4'b1110, CODE_A=4'b1111.
  - typedef disp_code_t as a 4-bit logic.
  - Shared by this block and the decoder.
- Sub-module scan_prescaler(clk, reset, tick): a generic modulo-SCAN_DIV tick generator, reusable by other timed blocks.
- Everything else stays in digit_scan_ctrl.

Test Plan (DIGITS=4, SCAN_DIV=4, BLINK_FRAMES=2):
1. Reset mid-scan after a load:
   - Expected after reset: num=4'hC, dig_sel=4'b1111, ld_ready=1 in the same cycle.
   - Expected after release: the first scan shows blanks.
2. Load ld_data=16'h4321 with ld_valid held for one cycle:
   - ld_ready=0 until frame_tick.
   - Subsequent frame shows num sequence 1,2,3,4, each held 4 cycles.
   - dig_sel goes 1110,1101,1011,0111, each lagging num by exactly 1 cycle.
3. Second load (16'hABCD) issued while ld_ready=0: ignored until ld_ready rises. The displayed frame never mixes 4321 and DCBA digits.
4. Load asserted in the frame_end cycle: captured, but the display updates only at the next frame_end, i.e. 16 cycles later.
5. blink_mask=4'b0010 with frame 16'h4321:
   - Digit 1 shows 2 for 2 frames, then C for 2 frames, repeating.
   - Other digits are never blanked.
6. LEADING_ZERO_BLANK_EN defined:
   - Frame 16'h0050 shows codes 0, 5, then C for digits 2 and 3.
   - Frame 16'h0000 shows C,C,C,0 from digit 3 down to digit 0.
